// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Entry layout at the default widths; the fetch unit re-declares it at its own widths.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory port and decoder handshake of the fetch unit.
interface instruction_fetch_if #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32
);
  logic [WORDSIZE-1:0]         imem_addr;
  logic [INSTRUCTION_SIZE-1:0] imem_instruction;
  logic                        out_valid;
  logic                        out_ready;
  logic [INSTRUCTION_SIZE-1:0] out_instruction;
  logic [WORDSIZE-1:0]         out_pc;

  modport master (
    output imem_addr, out_valid, out_instruction, out_pc,
    input  imem_instruction, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instruction, out_pc,
    output imem_instruction, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head reads zero while empty.
module fetch_queue #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_pkg::fetch_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   enq,
  input  logic   deq,
  input  entry_t enq_data,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enq_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? entry_t'(0) : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC, IDLE/RUN control and a fetch queue toward the decoder.
// Defining FETCH_PERF_COUNT_EN adds the 32-bit fetch_count enqueue counter output.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
  parameter int                  QUEUE_DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [WORDSIZE-1:0]  redirect_pc,
  instruction_fetch_if.master  bus
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]          fetch_count
`endif
);

  typedef struct packed {
    logic [WORDSIZE-1:0]         pc;
    logic [INSTRUCTION_SIZE-1:0] instruction;
  } entry_t;

  fetch_state_t        state;
  logic [WORDSIZE-1:0] pc;
  logic                do_enq;
  logic                do_deq;
  logic                full;
  logic                empty;
  entry_t              head;

  // Redirect squashes both queue movements in the cycle it is raised.
  assign do_deq = !empty && bus.out_ready && !redirect_valid;
  assign do_enq = (state == RUN) && !redirect_valid && (!full || do_deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE:    if (fetch_en) state <= RUN;
        RUN:     if (!fetch_en && !redirect_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (redirect_valid)
        pc <= redirect_pc & ~WORDSIZE'(INSTR_BYTES - 1);
      else if (do_enq)
        pc <= pc + WORDSIZE'(INSTR_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .enq      (do_enq),
    .deq      (do_deq),
    .enq_data ('{pc: pc, instruction: bus.imem_instruction}),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign bus.imem_addr       = {2'b00, pc[WORDSIZE-1:2]};
  assign bus.out_valid       = !empty;
  assign bus.out_instruction = head.instruction;
  assign bus.out_pc          = head.pc;

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)       fetch_count <= '0;
    else if (do_enq) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
- REQ-001 SHALL have parameter WORDSIZE, default 64: width of PC and memory address.
- REQ-002 SHALL have parameter INSTRUCTION_SIZE, default 32: instruction width.
- REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
- REQ-004 SHALL have parameter QUEUE_DEPTH, default 2: fetch queue entries, power of two, at least 2.
- REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-007 SHALL have port fetch_en, input, 1: fetching permitted.
- REQ-008 SHALL have port imem_addr, output, WORDSIZE: word index to instruction memory.
- REQ-009 SHALL have port imem_instruction, input, INSTRUCTION_SIZE: combinational memory read data for imem_addr.
- REQ-010 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
- REQ-011 SHALL have port redirect_pc, input, WORDSIZE: redirect target byte address.
- REQ-012 SHALL have port out_valid, output, 1: queue head holds an instruction.
- REQ-013 SHALL have port out_ready, input, 1: decoder accepts the head.
- REQ-014 SHALL have port out_instruction, output, INSTRUCTION_SIZE: head instruction.
- REQ-015 SHALL have port out_pc, output, WORDSIZE: byte address of the head instruction.

Function
- REQ-016 SHALL drive imem_addr = {2'b00, pc[WORDSIZE-1:2]} combinationally from the PC register; the PC is a byte address.
- REQ-017 SHALL implement FSM IDLE/RUN: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0 and redirect_valid=0. No fetch occurs in IDLE.
- REQ-018 SHALL, in RUN, enqueue {pc, imem_instruction} and advance pc by 4 in any cycle where count<QUEUE_DEPTH or a dequeue occurs in the same cycle.
- REQ-019 SHALL count a dequeue when out_valid=1 and out_ready=1; head contents SHALL remain stable while out_valid=1 and out_ready=0.
- REQ-020 SHALL give redirect_valid priority over all other activity in any state: queue flushed (count=0), pc<=redirect_pc with bits [1:0] forced to 0, and no enqueue or dequeue counted that cycle.
- REQ-021 SHALL have fetch latency 1: an instruction enqueued in cycle N is visible on out_valid/out_instruction in cycle N+1.
- REQ-022 SHALL allow simultaneous enqueue and dequeue when full, leaving count unchanged; with count=0, no enqueue, and no dequeue, out_valid SHALL be 0.
- REQ-023 SHALL wrap pc modulo 2^WORDSIZE and queue pointers modulo QUEUE_DEPTH.
- REQ-024 SHALL hold pc while the queue is full without a dequeue, so no instruction is skipped or duplicated.

Reset
- REQ-025 SHALL, on reset=1 at a clock edge, set pc=RESET_PC, state=IDLE, count=0, out_valid=0, out_instruction=0, out_pc=0, and any perf counter=0; reset SHALL override redirect.
- REQ-026 SHALL discard all queued entries when reset asserts mid-operation, and SHALL resume fetching at RESET_PC.

Configuration
- REQ-027 SHALL, with FETCH_PERF_COUNT_EN defined, add output fetch_count (32 bits), which increments by 1 per enqueue, wraps at 2^32, and is not cleared by redirect.
- REQ-028 SHALL, without FETCH_PERF_COUNT_EN, have no fetch_count port and no counter logic.

Structure
- REQ-029 SHALL place the following in shared package fetch_pkg: the state enum typedef (IDLE, RUN), the queue entry struct {pc, instruction}, and constant INSTR_BYTES=4.
- REQ-030 SHALL implement the queue as sub-module fetch_queue (parameterised synchronous FIFO with flush, enq, deq, full, empty, and head outputs).

Verification
- REQ-031 SHALL cover: reset, fetch_en=1, out_ready=1, memory words 0..3 = A,B,C,D -> out_pc 0,4,8,12 with A,B,C,D on consecutive cycles from cycle 2.
- REQ-032 SHALL cover: out_ready=0 for 5 cycles -> count saturates at 2, pc holds at 8, head stays pc=0/A; then out_ready=1 -> order A,B,C with no gap or duplicate.
- REQ-033 SHALL cover: redirect_valid=1, redirect_pc=0x43 while the queue holds 2 entries -> next cycle out_valid=0, imem_addr=0x10; the following cycle out_pc=0x40.
- REQ-034 SHALL cover: redirect and reset in the same cycle -> pc=RESET_PC, state=IDLE.
- REQ-035 SHALL cover: fetch_en dropped mid-stream -> no new enqueues, remaining entries drain, pc frozen.
- REQ-036 SHALL cover, with FETCH_PERF_COUNT_EN defined: 10 enqueues including one redirect -> fetch_count=10.
